mio_bus_bridge: RTL



---
 rtl/mio_bus_bridge.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mio_bus_bridge.sv
// Memory/IO bridge between the multi-cycle CPU control unit and block RAM,
// GPIO/LED register, switch inputs and a free-running cycle counter.
module mio_bus_bridge #(
   parameter int RAM_AW  = 10,
   parameter int RAM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              CPU_MIO,
   input  logic [31:0]       Addr_in,
   input  logic [31:0]       Data_from_cpu,
   output logic [31:0]       Data_to_cpu,
   output logic              MIO_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       sw_in,
   output logic [31:0]       led_out,
   output logic              bus_err
);

   typedef enum logic [1:0] {IDLE, RAM_WAIT, PERIPH, DONE} state_t;

   localparam logic [1:0] P_SW    = 2'd0;  // GPIO offset 0x0: switches / LED write
   localparam logic [1:0] P_LEDRD = 2'd1;  // GPIO offset 0x4: LED readback
   localparam logic [1:0] P_CNT   = 2'd2;
   localparam logic [1:0] P_BAD   = 2'd3;
   localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

   state_t            state_q;
   logic              wr_q;
   logic [1:0]        psel_q;
   logic [31:0]       wdata_q;
   logic [2:0]        wait_q;
   logic              mio_ready_q;
   logic              ram_we_q;
   logic [RAM_AW-1:0] ram_addr_q;
   logic [31:0]       ram_din_q;
   logic [31:0]       rdata_q;
   logic [31:0]       led_q;
   logic [31:0]       cnt_q;
   logic              err_q;

   logic [1:0]        psel_d;
   logic              is_ram_d;
   logic              req_d;
   logic              unused_addr;

   assign unused_addr = ^Addr_in[1:0];
   assign req_d       = CPU_MIO & (MemRead | MemWrite);
   assign is_ram_d    = (Addr_in[31:28] == 4'h0);

   // Peripheral target is resolved at acceptance so PERIPH only needs psel_q.
   always_comb begin
      psel_d = P_BAD;
      case (Addr_in[31:28])
         4'hE: begin
            if (Addr_in[27:2] == 26'd0)      psel_d = P_SW;
            else if (Addr_in[27:2] == 26'd1) psel_d = P_LEDRD;
         end
         4'hF:    psel_d = P_CNT;
         default: psel_d = P_BAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         psel_q      <= P_BAD;
         wdata_q     <= '0;
         wait_q      <= '0;
         mio_ready_q <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         rdata_q     <= '0;
         led_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         mio_ready_q <= 1'b0;
         ram_we_q    <= 1'b0;
         cnt_q       <= cnt_q + 32'd1;
         case (state_q)
            IDLE: begin
               if (req_d) begin
                  wr_q       <= MemWrite;
                  psel_q     <= psel_d;
                  wdata_q    <= Data_from_cpu;
                  wait_q     <= '0;
                  ram_addr_q <= Addr_in[RAM_AW+1:2];
                  ram_din_q  <= Data_from_cpu;
                  if (MemRead && MemWrite) err_q <= 1'b1;
                  if (is_ram_d) begin
                     // Write strobe lands in the first RAM_WAIT cycle.
                     ram_we_q <= MemWrite;
                     state_q  <= RAM_WAIT;
                  end else begin
                     state_q  <= PERIPH;
                  end
               end
            end
            RAM_WAIT: begin
               if (wr_q) begin
                  state_q     <= DONE;
                  mio_ready_q <= 1'b1;
               end else if (wait_q == LAT_LAST) begin
                  rdata_q     <= ram_dout;
                  state_q     <= DONE;
                  mio_ready_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + 3'd1;
               end
            end
            PERIPH: begin
               state_q     <= DONE;
               mio_ready_q <= 1'b1;
               case (psel_q)
                  P_SW: begin
                     if (wr_q) led_q   <= wdata_q;
                     else      rdata_q <= {16'h0000, sw_in};
                  end
                  P_LEDRD: begin
                     if (!wr_q) rdata_q <= led_q;
                  end
                  P_CNT: begin
                     // Overrides the increment above.
                     if (wr_q) cnt_q   <= wdata_q;
                     else      rdata_q <= cnt_q;
                  end
                  default: begin
                     err_q <= 1'b1;
                     if (!wr_q) rdata_q <= '0;
                  end
               endcase
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Data_to_cpu = rdata_q;
   assign MIO_ready   = mio_ready_q;
   assign ram_addr    = ram_addr_q;
   assign ram_din     = ram_din_q;
   assign ram_we      = ram_we_q;
   assign led_out     = led_q;
   assign bus_err     = err_q;

endmodule
